// File: rtl/ov5640_sccb_master_if.sv
// Command/status bundle between the HPS register bridge (master) and the SCCB writer (slave).
// Latency: n/a (wires only).  Backpressure: the bridge may issue start only after seeing ready high.
interface ov5640_sccb_master_if;
    logic        start;
    logic [15:0] address;
    logic [7:0]  data;
    logic        ready;
    logic        busy;
    logic        done;
    logic        ack_err;
    logic        cmd_overflow;

    modport master (
        output start, address, data,
        input  ready, busy, done, ack_err, cmd_overflow
    );

    modport slave (
        input  start, address, data,
        output ready, busy, done, ack_err, cmd_overflow
    );
endinterface

// File: rtl/ov5640_sccb_master.sv
// SCCB 3-phase register writer for the OV5640; SCCB_ACK_CHECK_EN enables NACK detection and early STOP.
// Latency: start to done = 156*CLK_DIV clk_sys cycles (shorter after a NACK when the check is enabled).
// Backpressure: ready is low while a frame is in flight; a start then is dropped and latches cmd_overflow.
module ov5640_sccb_master #(
    parameter int unsigned CLK_DIV  = 125,
    parameter logic [7:0]  DEV_ADDR = 8'h78
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,
    ov5640_sccb_master_if.slave        cmd,
    output logic                       sioc,
    output logic                       siod_oe,
    input  logic                       siod_in
);
    typedef enum logic [2:0] {IDLE, START, BIT, STOP, GAP} state_t;

    localparam logic [15:0] CNT_MAX = 16'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [1:0]  q_q, q_d;
    logic [15:0] cnt_q, cnt_d;
    logic [5:0]  slot_q, slot_d;
    logic [3:0]  bidx_q, bidx_d;
    logic [31:0] shreg_q, shreg_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic        sioc_d, oe_d;
    logic        tick, capture, abort;

    assign capture          = cmd.start && (state_q == IDLE);
    assign tick             = (state_q != IDLE) && (cnt_q == CNT_MAX);
    assign cmd.ready        = (state_q == IDLE) && !cmd.start;
    assign cmd.busy         = busy_q;
    assign cmd.done         = done_q;
    assign cmd.cmd_overflow = ovf_q;

`ifdef SCCB_ACK_CHECK_EN
    logic nack_q, ack_err_q, nack_set;

    // bidx 8 is the ninth (ACK) slot of each byte; the sensor must hold SIOD low there
    assign nack_set = tick && (state_q == BIT) && (q_q == 2'd2) && (bidx_q == 4'd8) && siod_in;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            nack_q    <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            if (capture)
                nack_q <= 1'b0;
            else if (nack_set)
                nack_q <= 1'b1;
            if (nack_set)
                ack_err_q <= 1'b1;
        end
    end

    assign abort       = nack_q;
    assign cmd.ack_err = ack_err_q;
`else
    logic unused_siod_in;
    assign unused_siod_in = siod_in;
    assign abort          = 1'b0;
    assign cmd.ack_err    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        bidx_d  = bidx_q;
        shreg_d = shreg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q | (cmd.start && (state_q != IDLE));

        if (capture) begin
            state_d = START;
            q_d     = 2'd0;
            cnt_d   = '0;
            slot_d  = '0;
            bidx_d  = '0;
            shreg_d = {DEV_ADDR, cmd.address, cmd.data};
            busy_d  = 1'b1;
        end else if (state_q != IDLE) begin
            cnt_d = tick ? '0 : cnt_q + 16'd1;
            if (tick) begin
                q_d = q_q + 2'd1;
                if (q_q == 2'd3) begin
                    case (state_q)
                        START: state_d = BIT;
                        BIT: begin
                            slot_d = slot_q + 6'd1;
                            if (bidx_q == 4'd8) begin
                                bidx_d = 4'd0;
                            end else begin
                                bidx_d  = bidx_q + 4'd1;
                                shreg_d = {shreg_q[30:0], 1'b0};
                            end
                            if ((slot_q == 6'd35) || abort)
                                state_d = STOP;
                        end
                        STOP: state_d = GAP;
                        GAP: begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        end

        // Pins are decoded from the quarter being entered so the registered outputs line up with it
        sioc_d = 1'b1;
        oe_d   = 1'b0;
        case (state_d)
            START: begin
                sioc_d = (q_d != 2'd3);
                oe_d   = (q_d != 2'd0);
            end
            BIT: begin
                sioc_d = (q_d == 2'd1) || (q_d == 2'd2);
                oe_d   = (bidx_d != 4'd8) && !shreg_d[31];
            end
            STOP: begin
                sioc_d = (q_d != 2'd0);
                oe_d   = (q_d <= 2'd1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            slot_q  <= '0;
            bidx_q  <= '0;
            shreg_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            sioc    <= 1'b1;
            siod_oe <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            bidx_q  <= bidx_d;
            shreg_q <= shreg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            sioc    <= sioc_d;
            siod_oe <= oe_d;
        end
    end
endmodule
